// File: rtl/uart_rx.sv
// uart_rx: 8N1-style serial receiver. Synchronises the asynchronous rx line,
// hunts for a start bit on oversampling ticks, samples each data bit at its
// centre (LSB first), checks the stop bit and presents the received word on a
// valid/ready handshake with one-clock framing-error and overrun pulses.
module uart_rx #(
    parameter int DATA_BITS   = 8,
    parameter int OVERSAMPLE  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 baud_tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 data_valid,
    input  logic                 data_ready,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);

    // Tick-count thresholds: centre of the start bit, then one full bit time.
    localparam logic [TW-1:0] T_HALF = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] T_FULL = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_STOP  = 3'd3;
    localparam logic [2:0] S_BREAK = 3'd4;

    logic [SYNC_STAGES-1:0] sync;
    logic                   rx_s;
    logic [2:0]             state;
    logic [TW-1:0]          tcnt;
    logic [BW-1:0]          bcnt;
    logic [DATA_BITS-1:0]   shreg;
    logic                   stop_sample;
    logic                   load;
    logic                   bad_stop;

    assign rx_s = sync[SYNC_STAGES-1];
    assign busy = (state != S_IDLE);

    // Metastability chain on the asynchronous rx pin; resets to the idle level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync <= '1;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], rx};
        end
    end

    // Stop-bit centre decision: good stop loads the word, bad stop flags an error.
    always_comb begin
        stop_sample = baud_tick && (state == S_STOP) && (tcnt == T_FULL);
        load        = stop_sample && rx_s;
        bad_stop    = stop_sample && !rx_s;
    end

    // Deframing state machine; advances only on oversampling ticks.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            tcnt  <= '0;
            bcnt  <= '0;
            shreg <= '0;
        end else if (baud_tick) begin
            case (state)
                S_IDLE: begin
                    if (!rx_s) begin
                        state <= S_START;
                        tcnt  <= '0;
                    end
                end
                S_START: begin
                    if (tcnt == T_HALF) begin
                        if (rx_s) begin
                            state <= S_IDLE;
                        end else begin
                            state <= S_DATA;
                            tcnt  <= '0;
                            bcnt  <= '0;
                        end
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end
                S_DATA: begin
                    if (tcnt == T_FULL) begin
                        shreg <= {rx_s, shreg[DATA_BITS-1:1]};
                        tcnt  <= '0;
                        bcnt  <= bcnt + BW'(1);
                        if (bcnt == B_LAST) begin
                            state <= S_STOP;
                        end
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end
                S_STOP: begin
                    if (tcnt == T_FULL) begin
                        state <= rx_s ? S_IDLE : S_BREAK;
                        tcnt  <= '0;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end
                S_BREAK: begin
                    if (rx_s) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Output register: handshake runs every clock; a new load overrides the
    // acceptance clear so a same-edge accept+load keeps valid high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data       <= '0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            frame_err <= bad_stop;
            overrun   <= 1'b0;
            if (data_valid && data_ready) begin
                data_valid <= 1'b0;
            end
            if (load) begin
                data       <= shreg;
                data_valid <= 1'b1;
                if (data_valid && !data_ready) begin
                    overrun <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: drives serial frames (baud_tick every 4 clk, 16 ticks per bit)
// and checks delivered words against a queue of expected bytes.
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       baud_tick = 1'b0;
    logic       rx = 1'b1;
    logic       data_ready = 1'b0;
    logic [7:0] data;
    logic       data_valid;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int tick_div = 0;
    int fe_cnt = 0;
    int ov_cnt = 0;
    int rise_cnt = 0;
    int run_len = 0;
    int max_run = 0;
    int t_start = 0;
    int t_valid = 0;
    logic prev_valid = 1'b0;

    logic [7:0] exp_q[$];
    logic [7:0] obs_q[$];

    uart_rx #(
        .DATA_BITS(8),
        .OVERSAMPLE(16),
        .SYNC_STAGES(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .baud_tick(baud_tick),
        .rx(rx),
        .data(data),
        .data_valid(data_valid),
        .data_ready(data_ready),
        .frame_err(frame_err),
        .overrun(overrun),
        .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        tick_div = (tick_div + 1) % 4;
        baud_tick = (tick_div == 0);
    end

    // Monitor: record every word load (valid rise, or overwrite via overrun).
    always @(negedge clk) begin
        if (!rst) begin
            if (frame_err) fe_cnt++;
            if (overrun) ov_cnt++;
            if ((data_valid && !prev_valid) || overrun) obs_q.push_back(data);
            if (data_valid && !prev_valid) begin
                rise_cnt++;
                t_valid = cyc;
            end
            if (data_valid) begin
                run_len++;
                if (run_len > max_run) max_run = run_len;
            end else begin
                run_len = 0;
            end
        end
        prev_valid = data_valid;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input bit want);
        if (want) exp_q.push_back(b);
        @(negedge clk);
        rx = 1'b0;
        t_start = cyc;
        repeat (64) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (64) @(negedge clk);
        end
        rx = stop_bit;
        repeat (64) @(negedge clk);
    endtask

    task automatic accept();
        @(negedge clk);
        data_ready = 1'b1;
        @(negedge clk);
        data_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        rx = 1'b1;
        data_ready = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (data !== 8'h00) begin errors++; $display("FAIL rst_data: got %h want 00", data); end
        checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", data_valid); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL rst_ferr: got %b want 0", frame_err); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL rst_ovr: got %b want 0", overrun); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
        rst = 1'b0;
        repeat (8) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b want 0", busy); end
    endtask

    task automatic test_frame();
        int fe0;
        int n;
        int lat;
        logic [7:0] e;
        logic [7:0] o;
        fe0 = fe_cnt;
        data_ready = 1'b0;
        send_frame(8'hA5, 1'b1, 1'b1);
        n = 0;
        while (!data_valid && n < 1000) begin @(negedge clk); n++; end
        repeat (4) @(negedge clk);
        checks++; if (data_valid !== 1'b1) begin errors++; $display("FAIL t1_valid: got %b want 1", data_valid); end
        checks++; if (data !== 8'hA5) begin errors++; $display("FAIL t1_data: got %h want a5", data); end
        lat = t_valid - t_start;
        checks++; if (lat < 608 || lat > 616) begin errors++; $display("FAIL t1_latency: got %0d clk want 608..616", lat); end
        checks++; if (obs_q.size() !== exp_q.size()) begin errors++; $display("FAIL t1_sb_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++; if (o !== e) begin errors++; $display("FAIL t1_sb_byte: got %h want %h", o, e); end
        end
        exp_q.delete(); obs_q.delete();
        repeat (200) @(negedge clk);
        checks++; if (data_valid !== 1'b1 || data !== 8'hA5) begin errors++; $display("FAIL t1_hold: got valid=%b data=%h want 1/a5", data_valid, data); end
        checks++; if (fe_cnt - fe0 !== 0) begin errors++; $display("FAIL t1_ferr: got %0d want 0", fe_cnt - fe0); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL t1_busy: got %b want 0", busy); end
        accept();
        checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL t1_accept: got %b want 0", data_valid); end
    endtask

    task automatic test_glitch();
        int fe0;
        int r0;
        logic seen;
        fe0 = fe_cnt;
        r0 = rise_cnt;
        @(negedge clk);
        rx = 1'b0;
        repeat (12) @(negedge clk);
        seen = busy;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        repeat (24) @(negedge clk);
        checks++; if (seen !== 1'b1) begin errors++; $display("FAIL t2_busy_rise: got %b want 1", seen); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL t2_busy_fall: got %b want 0", busy); end
        repeat (200) @(negedge clk);
        checks++; if (rise_cnt - r0 !== 0) begin errors++; $display("FAIL t2_valid: got %0d want 0", rise_cnt - r0); end
        checks++; if (fe_cnt - fe0 !== 0) begin errors++; $display("FAIL t2_ferr: got %0d want 0", fe_cnt - fe0); end
        checks++; if (obs_q.size() !== 0) begin errors++; $display("FAIL t2_sb: got %0d want 0", obs_q.size()); end
        obs_q.delete();
    endtask

    task automatic test_frame_err();
        int fe0;
        int n;
        logic [7:0] e;
        logic [7:0] o;
        fe0 = fe_cnt;
        send_frame(8'h3C, 1'b0, 1'b0);
        repeat (19 * 64) @(negedge clk);
        rx = 1'b1;
        repeat (128) @(negedge clk);
        checks++; if (fe_cnt - fe0 !== 1) begin errors++; $display("FAIL t3_ferr_count: got %0d want 1", fe_cnt - fe0); end
        checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL t3_valid: got %b want 0", data_valid); end
        checks++; if (obs_q.size() !== 0) begin errors++; $display("FAIL t3_discard: got %0d want 0", obs_q.size()); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL t3_busy: got %b want 0", busy); end
        obs_q.delete();
        send_frame(8'h81, 1'b1, 1'b1);
        n = 0;
        while (!data_valid && n < 1000) begin @(negedge clk); n++; end
        repeat (4) @(negedge clk);
        checks++; if (data_valid !== 1'b1 || data !== 8'h81) begin errors++; $display("FAIL t3_recover: got valid=%b data=%h want 1/81", data_valid, data); end
        checks++; if (obs_q.size() !== exp_q.size()) begin errors++; $display("FAIL t3_sb_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++; if (o !== e) begin errors++; $display("FAIL t3_sb_byte: got %h want %h", o, e); end
        end
        exp_q.delete(); obs_q.delete();
        accept();
    endtask

    task automatic test_overrun();
        int ov0;
        logic [7:0] e;
        logic [7:0] o;
        ov0 = ov_cnt;
        data_ready = 1'b0;
        send_frame(8'h11, 1'b1, 1'b1);
        send_frame(8'h22, 1'b1, 1'b1);
        repeat (8) @(negedge clk);
        checks++; if (ov_cnt - ov0 !== 1) begin errors++; $display("FAIL t4_overrun: got %0d want 1", ov_cnt - ov0); end
        checks++; if (data_valid !== 1'b1 || data !== 8'h22) begin errors++; $display("FAIL t4_data: got valid=%b data=%h want 1/22", data_valid, data); end
        checks++; if (obs_q.size() !== exp_q.size()) begin errors++; $display("FAIL t4_sb_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++; if (o !== e) begin errors++; $display("FAIL t4_sb_byte: got %h want %h", o, e); end
        end
        exp_q.delete(); obs_q.delete();
        accept();
    endtask

    task automatic test_back_to_back();
        int ov0;
        logic [7:0] e;
        logic [7:0] o;
        ov0 = ov_cnt;
        max_run = 0;
        run_len = 0;
        data_ready = 1'b1;
        send_frame(8'h00, 1'b1, 1'b1);
        send_frame(8'hFF, 1'b1, 1'b1);
        repeat (8) @(negedge clk);
        data_ready = 1'b0;
        checks++; if (max_run !== 1) begin errors++; $display("FAIL t5_valid_width: got %0d want 1", max_run); end
        checks++; if (ov_cnt - ov0 !== 0) begin errors++; $display("FAIL t5_overrun: got %0d want 0", ov_cnt - ov0); end
        checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL t5_valid: got %b want 0", data_valid); end
        checks++; if (obs_q.size() !== exp_q.size()) begin errors++; $display("FAIL t5_sb_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++; if (o !== e) begin errors++; $display("FAIL t5_sb_byte: got %h want %h", o, e); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] e;
        logic [7:0] o;
        data_ready = 1'b0;
        send_frame(8'h77, 1'b1, 1'b1);
        repeat (8) @(negedge clk);
        checks++; if (data_valid !== 1'b1 || data !== 8'h77) begin errors++; $display("FAIL t6_pending: got valid=%b data=%h want 1/77", data_valid, data); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++; if (o !== e) begin errors++; $display("FAIL t6_sb_pending: got %h want %h", o, e); end
        end
        exp_q.delete(); obs_q.delete();
        fork
            send_frame(8'hC3, 1'b1, 1'b0);
            begin
                @(negedge clk);
                repeat (5 * 64 + 16) @(negedge clk);
                rst = 1'b1;
            end
        join
        repeat (2) @(negedge clk);
        checks++; if (data !== 8'h00) begin errors++; $display("FAIL t6_rst_data: got %h want 00", data); end
        checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL t6_rst_valid: got %b want 0", data_valid); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL t6_rst_ferr: got %b want 0", frame_err); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL t6_rst_ovr: got %b want 0", overrun); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL t6_rst_busy: got %b want 0", busy); end
        rst = 1'b0;
        repeat (64) @(negedge clk);
        checks++; if (obs_q.size() !== 0 || busy !== 1'b0) begin errors++; $display("FAIL t6_quiet: got loads=%0d busy=%b want 0/0", obs_q.size(), busy); end
        obs_q.delete();
        send_frame(8'h5A, 1'b1, 1'b1);
        repeat (8) @(negedge clk);
        checks++; if (data_valid !== 1'b1 || data !== 8'h5A) begin errors++; $display("FAIL t6_data: got valid=%b data=%h want 1/5a", data_valid, data); end
        checks++; if (obs_q.size() !== exp_q.size()) begin errors++; $display("FAIL t6_sb_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++; if (o !== e) begin errors++; $display("FAIL t6_sb_byte: got %h want %h", o, e); end
        end
        exp_q.delete(); obs_q.delete();
        accept();
    endtask

    initial begin
        test_reset();
        test_frame();
        test_glitch();
        test_frame_err();
        test_overrun();
        test_back_to_back();
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
